// File: rtl/matmul_mem_pkg.sv
// rtl/matmul_mem_pkg.sv - shared arbiter state type and requester indices for the matmul memory port
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 16
`endif
`ifndef OUTPUT_MAT_BASE_ADDR
`define OUTPUT_MAT_BASE_ADDR 32'h0000_1000
`endif
`ifndef MEM_ADDR_INCR
`define MEM_ADDR_INCR 4
`endif

package matmul_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam int REQ_WEIGHT = 0;
  localparam int REQ_INPUT  = 1;
  localparam int REQ_OUTPUT = 2;

endpackage

// File: rtl/matmul_mem_arbiter_rr_picker.sv
// rtl/matmul_mem_arbiter_rr_picker.sv - combinational round-robin picker starting the search at rr_ptr
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [IDX_W:0]       offset;
  logic [IDX_W:0]       sum;

  always_comb begin
    doubled = {req, req};
    rotated = NUM_REQ'(doubled >> rr_ptr);
    valid   = 1'b0;
    offset  = '0;
    // Scan from the far end so the requester closest to rr_ptr wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        valid  = 1'b1;
        offset = (IDX_W+1)'(i);
      end
    end
    sum = {1'b0, rr_ptr} + offset;
    if (sum >= (IDX_W+1)'(NUM_REQ)) begin
      sum = sum - (IDX_W+1)'(NUM_REQ);
    end
    winner = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/matmul_mem_arbiter.sv
// rtl/matmul_mem_arbiter.sv - single-port memory arbiter for the matmul loaders and output writer
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 16
`endif

module matmul_mem_arbiter
  import matmul_mem_pkg::*;
#(
  parameter int NUM_REQ            = 3,
  parameter int MEM_ACCESS_LATENCY = 2,
  parameter int DATA_W             = `MEM_PORT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*32-1:0]       req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic [31:0]                 mem_addr,
  output logic                        mem_wr_en,
  output logic                        mem_rd_en,
  output logic [DATA_W-1:0]           mem_data,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MEM_ACCESS_LATENCY + 1);

  arb_state_t         state;
  arb_state_t         next_state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W-1:0]   owner;
  logic               owner_we;
  logic [CNT_W-1:0]   wait_cnt;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               sel_we;
  logic               sel_lock;
  logic [31:0]        sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [NUM_REQ-1:0] owner_onehot;
  logic               capture;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_comb begin
    sel_we       = 1'b0;
    sel_lock     = 1'b0;
    sel_addr     = '0;
    sel_wdata    = '0;
    pick_onehot  = '0;
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_we         = req_we[i];
        sel_lock       = req_lock[i];
        sel_addr       = req_addr[i*32 +: 32];
        sel_wdata      = req_wdata[i*DATA_W +: DATA_W];
        pick_onehot[i] = 1'b1;
      end
      if (owner == IDX_W'(i)) begin
        owner_onehot[i] = 1'b1;
      end
    end
  end

  // A locked owner keeps the pointer so it is searched first next time.
  always_comb begin
    if (sel_lock) begin
      next_ptr = pick_idx;
    end else if (pick_idx == IDX_W'(NUM_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = pick_idx + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!stall && pick_valid) begin
          capture    = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (wait_cnt == '0) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are registered from the transition so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      owner     <= '0;
      owner_we  <= 1'b0;
      wait_cnt  <= '0;
      gnt       <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      rdata     <= '0;
    end else begin
      busy      <= (next_state != IDLE);
      gnt       <= '0;
      ack       <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            owner     <= pick_idx;
            owner_we  <= sel_we;
            mem_addr  <= sel_addr;
            mem_data  <= sel_wdata;
            rr_ptr    <= next_ptr;
            gnt       <= pick_onehot;
            mem_wr_en <= sel_we;
            mem_rd_en <= !sel_we;
          end
        end
        ISSUE: begin
          wait_cnt <= CNT_W'(MEM_ACCESS_LATENCY - 1);
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            if (!owner_we) begin
              rdata <= mem_rdata;
            end
            ack <= owner_onehot;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_mem_arbiter.sv
// tb/tb_matmul_mem_arbiter.sv - scoreboard bench for the matmul memory arbiter
module tb_matmul_mem_arbiter;

  localparam int L  = 2;
  localparam int N  = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_we = '0;
  logic [N-1:0]  req_lock = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [31:0]   mem_addr;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          owner;
    bit          we;
    logic [15:0] rdata;
  } resp_t;

  int    exp_gnt_q[$];
  resp_t exp_resp_q[$];

  logic [15:0] mem_store [bit [31:0]];
  logic [15:0] pipe [0:L-1];

  matmul_mem_arbiter #(
    .NUM_REQ            (N),
    .MEM_ACCESS_LATENCY (L),
    .DATA_W             (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .req       (req),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_data  (mem_data),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_val(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return a[15:0] ^ 16'hC3C3;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Memory model: data for an enable cycle appears L cycles later.
  assign mem_rdata = pipe[L-1];
  always @(posedge clk) begin
    if (mem_wr_en) mem_store[mem_addr] = mem_data;
    pipe[0] <= mem_rd_en ? mem_val(mem_addr) : 16'hDEAD;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  task automatic wait_gnt(input int budget, output int n, output bit seen);
    n = 0; seen = 0;
    while (n < budget && !seen) begin
      @(negedge clk); n++;
      if (gnt != '0) seen = 1;
    end
  endtask

  task automatic wait_ack(input int budget, output int n, output bit seen);
    n = 0; seen = 0;
    while (n < budget && !seen) begin
      @(negedge clk); n++;
      if (ack != '0) seen = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== '0 || ack !== '0) begin failures++; $display("FAIL reset_gnt_ack gnt=%b ack=%b required 0", gnt, ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required 0", busy); end
    checks++; if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_en wr=%b rd=%b required 0", mem_wr_en, mem_rd_en); end
    checks++; if (mem_addr !== '0 || mem_data !== '0 || rdata !== '0) begin failures++; $display("FAIL reset_data addr=%h data=%h rdata=%h required 0", mem_addr, mem_data, rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int n; bit seen; int o; resp_t r;
    req_addr[1*32 +: 32] = 32'h40; req_we[1] = 1'b0; req = 3'b010;
    exp_gnt_q.push_back(1);
    exp_resp_q.push_back('{1, 1'b0, mem_val(32'h40)});
    wait_gnt(8, n, seen);
    req = '0;
    checks++; if (!seen || n !== 1) begin failures++; $display("FAIL rd_gnt_latency got=%0d required 1", n); end
    o = exp_gnt_q.pop_front();
    checks++; if (gnt !== oh(o)) begin failures++; $display("FAIL rd_gnt got=%b required %b", gnt, oh(o)); end
    checks++; if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0) begin failures++; $display("FAIL rd_enables rd=%b wr=%b required 1/0", mem_rd_en, mem_wr_en); end
    checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL rd_addr got=%h required 40", mem_addr); end
    wait_ack(8, n, seen);
    checks++; if (!seen || n !== L + 1) begin failures++; $display("FAIL rd_ack_latency got=%0d required %0d", n, L + 1); end
    r = exp_resp_q.pop_front();
    checks++; if (ack !== oh(r.owner)) begin failures++; $display("FAIL rd_ack got=%b required %b", ack, oh(r.owner)); end
    checks++; if (rdata !== 16'hABCD || rdata !== r.rdata) begin failures++; $display("FAIL rd_data got=%h required %h", rdata, r.rdata); end
  endtask

  task automatic test_single_write();
    int n; int wr; bit seen; int o; resp_t r;
    @(negedge clk);
    req_addr[2*32 +: 32] = 32'h100; req_wdata[2*DW +: DW] = 16'h1234; req_we[2] = 1'b1; req = 3'b100;
    exp_gnt_q.push_back(2);
    exp_resp_q.push_back('{2, 1'b1, 16'h0});
    wait_gnt(8, n, seen);
    req = '0;
    o = exp_gnt_q.pop_front();
    checks++; if (!seen || gnt !== oh(o)) begin failures++; $display("FAIL wr_gnt got=%b required %b", gnt, oh(o)); end
    checks++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0) begin failures++; $display("FAIL wr_enables wr=%b rd=%b required 1/0", mem_wr_en, mem_rd_en); end
    checks++; if (mem_data !== 16'h1234 || mem_addr !== 32'h100) begin failures++; $display("FAIL wr_data data=%h addr=%h required 1234/100", mem_data, mem_addr); end
    n = 0; wr = 0;
    while (n < 8 && ack == '0) begin
      @(negedge clk); n++;
      if (mem_wr_en) wr++;
    end
    r = exp_resp_q.pop_front();
    checks++; if (wr !== 0) begin failures++; $display("FAIL wr_en_width extra_cycles=%0d required 0", wr); end
    checks++; if (n !== L + 1 || ack !== oh(r.owner)) begin failures++; $display("FAIL wr_ack n=%0d ack=%b required %0d/%b", n, ack, L + 1, oh(r.owner)); end
    req_we[2] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n; bit seen; int o; int prev; resp_t r;
    @(negedge clk);
    for (int i = 0; i < N; i++) req_addr[i*32 +: 32] = 32'h200 + 32'(i * 4);
    req_we = '0; req = 3'b111;
    for (int k = 0; k < 6; k++) exp_gnt_q.push_back(k % 3);
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(12, n, seen);
      if (k == 5) req = '0;
      o = exp_gnt_q.pop_front();
      checks++; if (!seen || gnt !== oh(o)) begin failures++; $display("FAIL rr_order k=%0d got=%b required %b", k, gnt, oh(o)); end
      if (k > 0) begin
        checks++; if (cyc - prev !== L + 3) begin failures++; $display("FAIL rr_spacing k=%0d got=%0d required %0d", k, cyc - prev, L + 3); end
      end
      prev = cyc;
      exp_resp_q.push_back('{o, 1'b0, mem_val(32'h200 + 32'(o * 4))});
      wait_ack(8, n, seen);
      r = exp_resp_q.pop_front();
      checks++; if (!seen || ack !== oh(r.owner) || rdata !== r.rdata) begin failures++; $display("FAIL rr_resp k=%0d ack=%b rdata=%h required %b/%h", k, ack, rdata, oh(r.owner), r.rdata); end
    end
  endtask

  task automatic test_lock();
    int n; bit seen; int o;
    @(negedge clk);
    req_lock = 3'b001; req_we = '0; req = 3'b111;
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(0); exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(12, n, seen);
      if (k == 1) req_lock = '0;
      if (k == 3) req = '0;
      o = exp_gnt_q.pop_front();
      checks++; if (!seen || gnt !== oh(o)) begin failures++; $display("FAIL lock_order k=%0d got=%b required %b", k, gnt, oh(o)); end
      wait_ack(8, n, seen);
    end
  endtask

  task automatic test_stall();
    int n; bit seen; int o; resp_t r;
    @(negedge clk);
    stall = 1'b1;
    req_addr[2*32 +: 32] = 32'h300; req_we[2] = 1'b0; req = 3'b100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (gnt !== '0 || busy !== 1'b0) begin failures++; $display("FAIL stall_hold k=%0d gnt=%b busy=%b required 0/0", k, gnt, busy); end
    end
    stall = 1'b0;
    exp_gnt_q.push_back(2);
    exp_resp_q.push_back('{2, 1'b0, mem_val(32'h300)});
    wait_gnt(6, n, seen);
    req = '0;
    o = exp_gnt_q.pop_front();
    checks++; if (!seen || gnt !== oh(o)) begin failures++; $display("FAIL stall_release got=%b required %b", gnt, oh(o)); end
    @(negedge clk);
    stall = 1'b1;
    wait_ack(8, n, seen);
    r = exp_resp_q.pop_front();
    checks++; if (!seen || n !== L || ack !== oh(r.owner) || rdata !== r.rdata) begin failures++; $display("FAIL stall_inflight n=%0d ack=%b rdata=%h required %0d/%b/%h", n, ack, rdata, L, oh(r.owner), r.rdata); end
    stall = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int n; bit seen; int o; int stray; resp_t r;
    @(negedge clk);
    req_addr[1*32 +: 32] = 32'h400; req_we = '0; req = 3'b010;
    exp_gnt_q.push_back(1);
    wait_gnt(8, n, seen);
    req = '0;
    o = exp_gnt_q.pop_front();
    checks++; if (!seen || gnt !== oh(o)) begin failures++; $display("FAIL abort_gnt got=%b required %b", gnt, oh(o)); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || ack !== '0 || gnt !== '0 || mem_rd_en !== 1'b0) begin failures++; $display("FAIL abort_outputs busy=%b ack=%b gnt=%b rd=%b required 0", busy, ack, gnt, mem_rd_en); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL abort_addr got=%h required 0", mem_addr); end
    stray = 0;
    for (int k = 0; k < L + 3; k++) begin
      @(negedge clk);
      if (ack != '0) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL abort_no_ack got=%0d required 0", stray); end
    for (int i = 0; i < N; i++) req_addr[i*32 +: 32] = 32'h500 + 32'(i * 4);
    req = 3'b111;
    exp_gnt_q.push_back(0);
    wait_gnt(8, n, seen);
    req = '0;
    o = exp_gnt_q.pop_front();
    checks++; if (!seen || gnt !== oh(o)) begin failures++; $display("FAIL abort_ptr got=%b required %b", gnt, oh(o)); end
    exp_resp_q.push_back('{o, 1'b0, mem_val(32'h500 + 32'(o * 4))});
    wait_ack(8, n, seen);
    r = exp_resp_q.pop_front();
    checks++; if (!seen || ack !== oh(r.owner) || rdata !== r.rdata) begin failures++; $display("FAIL abort_next_resp ack=%b rdata=%h required %b/%h", ack, rdata, oh(r.owner), r.rdata); end
  endtask

  initial begin
    mem_store[32'h40] = 16'hABCD;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_lock();
    test_stall();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycles=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
